fifo_read_framer: RTL and testbench

FIFO_READ_FRAMER -- requirements
Module: fifo_read_framer

---
 rtl/fifo_read_framer.sv | 93 +++++++++
 tb/tb_fifo_read_framer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_framer.sv
// Pulls words from a FIFO read port and emits them as fixed-length frames,
// each followed by a checksum word (modular sum of the frame's data words).
module fifo_read_framer #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 8
) (
  input  logic              rd_clk,
  input  logic              rd_rst_n,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [7:0]        frame_cnt
);

  localparam logic [0:0] ST_DATA = 1'b0;
  localparam logic [0:0] ST_SUM  = 1'b1;
  localparam logic [7:0] LEN     = 8'(FRAME_LEN);

  logic [0:0]        state;
  logic              pend;
  logic [7:0]        word_cnt;
  logic [DATA_W-1:0] sum;

  logic out_free;
  logic xfer;
  logic sum_load;

  // The output register can take a new word when it is empty or being drained.
  assign out_free = !out_valid || out_ready;
  assign xfer     = out_valid && out_ready;
  assign sum_load = (state == ST_SUM) && out_free;

  // A pop is only issued when the word returned next cycle is sure to find the
  // output register free, so the returning word never needs to be buffered.
  assign fifo_rd_en = rd_rst_n && (state == ST_DATA) && !fifo_empty && !pend &&
                      (word_cnt < LEN) && out_free;

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state    <= ST_DATA;
      pend     <= 1'b0;
      word_cnt <= 8'd0;
      sum      <= '0;
    end else begin
      pend <= fifo_rd_en;
      if (fifo_rd_en) begin
        word_cnt <= word_cnt + 8'd1;
      end
      if (pend) begin
        sum <= sum + fifo_rd_data;
        if (word_cnt == LEN) begin
          state    <= ST_SUM;
          word_cnt <= 8'd0;
        end
      end else if (sum_load) begin
        sum   <= '0;
        state <= ST_DATA;
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (pend) begin
      out_data  <= fifo_rd_data;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
    end else if (sum_load) begin
      out_data  <= sum;
      out_valid <= 1'b1;
      out_last  <= 1'b1;
    end else if (xfer) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      frame_cnt <= 8'd0;
    end else if (xfer && out_last) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fifo_read_framer.sv
// Directed self-checking bench for fifo_read_framer: FIFO read-port model,
// transfer monitor, and a linear sequence of checked scenarios.
module tb_fifo_read_framer;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [15:0] fifo_rd_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [7:0]  frame_cnt;

  logic        fifo_empty1;
  logic        fifo_rd_en1;
  logic [15:0] fifo_rd_data1;
  logic [15:0] out_data1;
  logic        out_valid1;
  logic        ready1;
  logic        out_last1;
  logic [7:0]  frame_cnt1;

  int n_asserts = 0;
  int n_fail    = 0;
  int cycle     = 0;
  int rd_empty_viol = 0;
  int rd_rst_viol   = 0;

  logic [15:0] mem [0:8191];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [15:0] mem1 [0:15];
  int          wr1 = 0;
  int          rd1 = 0;

  logic [15:0] cap_data[$];
  logic        cap_last[$];
  int          cap_cycle[$];
  logic [15:0] cap1_data[$];
  logic        cap1_last[$];

  fifo_read_framer #(.DATA_W(16), .FRAME_LEN(8)) dut (
    .rd_clk(clk), .rd_rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_cnt(frame_cnt)
  );

  fifo_read_framer #(.DATA_W(16), .FRAME_LEN(1)) dut1 (
    .rd_clk(clk), .rd_rst_n(rst_n), .fifo_empty(fifo_empty1), .fifo_rd_en(fifo_rd_en1),
    .fifo_rd_data(fifo_rd_data1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(ready1), .out_last(out_last1), .frame_cnt(frame_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty  = (rd_ptr == wr_ptr);
  assign fifo_empty1 = (rd1 == wr1);

  // FIFO models: data appears the cycle after a pop; junk otherwise.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr[12:0]];
      rd_ptr       <= rd_ptr + 1;
    end else begin
      fifo_rd_data <= 16'hA5A5;
    end
    if (fifo_rd_en1) begin
      fifo_rd_data1 <= mem1[rd1[3:0]];
      rd1           <= rd1 + 1;
    end else begin
      fifo_rd_data1 <= 16'h5A5A;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      cap_data.push_back(out_data);
      cap_last.push_back(out_last);
      cap_cycle.push_back(cycle);
    end
    if (rst_n && out_valid1 && ready1) begin
      cap1_data.push_back(out_data1);
      cap1_last.push_back(out_last1);
    end
    if (fifo_rd_en && fifo_empty) rd_empty_viol++;
    if (!rst_n && (fifo_rd_en || fifo_rd_en1)) rd_rst_viol++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [15:0] w);
    mem[wr_ptr[12:0]] = w;
    wr_ptr++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearCaptures();
    cap_data.delete();
    cap_last.delete();
    cap_cycle.delete();
  endtask

  task automatic waitTransfers(input int n, input int budget, input string tag);
    int k = 0;
    while (cap_data.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput(tag, 32'(cap_data.size() >= n), 32'd1);
  endtask

  task automatic checkFrame(input string tag, input int base, input logic [15:0] first);
    for (int i = 0; i < 8; i++) begin
      checkOutput({tag, "_data"}, 32'(cap_data[base+i]), 32'(first + 16'(i)));
      checkOutput({tag, "_last0"}, 32'(cap_last[base+i]), 32'd0);
    end
    checkOutput({tag, "_sum"}, 32'(cap_data[base+8]), 32'(8*first + 28));
    checkOutput({tag, "_last1"}, 32'(cap_last[base+8]), 32'd1);
  endtask

  initial begin
    int base;
    int k;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    ready1    = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    for (int i = 1; i <= 8; i++) applyStimulus(16'(i));
    @(posedge clk); #1;
    checkOutput("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);

    // Basic frame 1..8, checksum 36, one word per two cycles
    rst_n = 1'b1;
    #1;
    checkOutput("first_fetch", 32'(fifo_rd_en), 32'd1);
    waitTransfers(9, 100, "basic_timeout");
    checkFrame("basic", 0, 16'd1);
    for (int i = 1; i < 8; i++)
      checkOutput("basic_gap", 32'(cap_cycle[i] - cap_cycle[i-1]), 32'd2);
    checkOutput("basic_frame_cnt", 32'(frame_cnt), 32'd1);

    // All-ones words: checksum wraps to 0xFFF8
    clearCaptures();
    for (int i = 0; i < 8; i++) applyStimulus(16'hFFFF);
    waitTransfers(9, 100, "ones_timeout");
    checkOutput("ones_data0", 32'(cap_data[0]), 32'h0000FFFF);
    checkOutput("ones_sum", 32'(cap_data[8]), 32'h0000FFF8);
    checkOutput("ones_last", 32'(cap_last[8]), 32'd1);
    checkOutput("ones_frame_cnt", 32'(frame_cnt), 32'd2);

    // Backpressure while word 5 is presented
    clearCaptures();
    for (int i = 1; i <= 8; i++) applyStimulus(16'(i));
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!(out_valid === 1'b1 && out_data === 16'd5) && k < 100);
    checkOutput("stall_reach5", 32'(out_data), 32'd5);
    out_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checkOutput("stall_hold_data", 32'(out_data), 32'd5);
      checkOutput("stall_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_rd_en", 32'(fifo_rd_en), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    waitTransfers(9, 100, "stall_timeout");
    checkFrame("stall", 0, 16'd1);
    checkOutput("stall_frame_cnt", 32'(frame_cnt), 32'd3);

    // FIFO runs dry after three words
    clearCaptures();
    for (int i = 1; i <= 3; i++) applyStimulus(16'(i));
    waitTransfers(3, 50, "dry_timeout_a");
    repeat (20) @(posedge clk);
    #1;
    checkOutput("dry_no_extra", 32'(cap_data.size()), 32'd3);
    checkOutput("dry_valid_low", 32'(out_valid), 32'd0);
    for (int i = 4; i <= 8; i++) applyStimulus(16'(i));
    waitTransfers(9, 100, "dry_timeout_b");
    repeat (5) @(posedge clk);
    #1;
    checkOutput("dry_count", 32'(cap_data.size()), 32'd9);
    checkFrame("dry", 0, 16'd1);
    checkOutput("dry_frame_cnt", 32'(frame_cnt), 32'd4);

    // Reset mid-frame while the fourth read is in flight; 40 must be dropped
    clearCaptures();
    base = wr_ptr;
    applyStimulus(16'd10);
    applyStimulus(16'd20);
    applyStimulus(16'd30);
    applyStimulus(16'd40);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(fifo_rd_en === 1'b1 && rd_ptr == base + 3) && k < 100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
    for (int i = 1; i <= 8; i++) applyStimulus(16'(i));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;
    waitTransfers(12, 100, "midrst_timeout");
    checkOutput("midrst_pre0", 32'(cap_data[0]), 32'd10);
    checkOutput("midrst_pre2", 32'(cap_data[2]), 32'd30);
    checkFrame("midrst", 3, 16'd1);
    checkOutput("midrst_frame_cnt_after", 32'(frame_cnt), 32'd1);

    // FRAME_LEN=1 instance: each word followed by itself as checksum
    mem1[0] = 16'h1234;
    mem1[1] = 16'hABCD;
    wr1 = 2;
    k = 0;
    while (cap1_data.size() < 4 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("len1_count", 32'(cap1_data.size()), 32'd4);
    checkOutput("len1_d0", 32'(cap1_data[0]), 32'h1234);
    checkOutput("len1_l0", 32'(cap1_last[0]), 32'd0);
    checkOutput("len1_s0", 32'(cap1_data[1]), 32'h1234);
    checkOutput("len1_l1", 32'(cap1_last[1]), 32'd1);
    checkOutput("len1_s1", 32'(cap1_data[3]), 32'hABCD);
    checkOutput("len1_frame_cnt", 32'(frame_cnt1), 32'd2);

    // 256 frames: frame_cnt wraps on the last checksum
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("wrap_start_cnt", 32'(frame_cnt), 32'd0);
    clearCaptures();
    for (int f = 0; f < 256; f++)
      for (int i = 0; i < 8; i++) applyStimulus(16'(f));
    waitTransfers(255*9, 6000, "wrap_timeout_a");
    checkOutput("wrap_cnt_255", 32'(frame_cnt), 32'd255);
    checkOutput("wrap_sum_254", 32'(cap_data[255*9-1]), 32'h07F0);
    waitTransfers(256*9, 200, "wrap_timeout_b");
    checkOutput("wrap_cnt_0", 32'(frame_cnt), 32'd0);
    checkOutput("wrap_sum_255", 32'(cap_data[256*9-1]), 32'h07F8);
    checkOutput("wrap_last", 32'(cap_last[256*9-1]), 32'd1);

    checkOutput("rd_en_while_empty", 32'(rd_empty_viol), 32'd0);
    checkOutput("rd_en_while_reset", 32'(rd_rst_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
